// File: rtl/axi_burst_master_pkg.sv
// Shared types and constants for the AXI4 write-then-read-back burst master.
// Burst geometry, response codes and the per-beat data pattern live here.
package axi_burst_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        FIN
    } state_t;

    localparam int BURST_LEN = 8;
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
    localparam logic [7:0] AXLEN = 8'(BURST_LEN - 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Top byte tags the run, low bits count beats from 1.
    function automatic logic [31:0] beat_word(
        input logic [7:0] run,
        input logic [2:0] beat
    );
        return {run, 24'(beat) + 24'd1};
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 master: one 8-beat INCR write burst, then reads it back and compares.
// All interface outputs come straight from flops; ERROR is sticky per run.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          START,
    output logic                          DONE,
    output logic                          ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    state_t      state;
    logic [7:0]  run_cnt;
    logic [2:0]  beat;
    logic        done_q;
    logic        error_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        wlast_q;
    logic [31:0] wdata_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;

    logic        rd_bad;

    assign M_AXI_AWADDR  = C_M_TARGET_BASE_ADDR;
    assign M_AXI_ARADDR  = C_M_TARGET_BASE_ADDR;
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;

    // A read beat is bad on data, response or a misplaced/missing RLAST.
    assign rd_bad = (M_AXI_RDATA != beat_word(run_cnt, beat))
                 || (M_AXI_RRESP != RESP_OKAY)
                 || (M_AXI_RLAST != (beat == LAST_BEAT));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            run_cnt   <= '0;
            beat      <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        error_q   <= 1'b0;
                        beat      <= '0;
                        awvalid_q <= 1'b1;
                        state     <= WADDR;
                    end
                end
                WADDR: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= beat_word(run_cnt, 3'd0);
                        wlast_q   <= 1'b0;
                        state     <= WDATA;
                    end
                end
                WDATA: begin
                    if (M_AXI_WREADY) begin
                        if (beat == LAST_BEAT) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            beat     <= '0;
                            state    <= WRESP;
                        end else begin
                            beat    <= beat + 3'd1;
                            wdata_q <= beat_word(run_cnt, beat + 3'd1);
                            wlast_q <= (beat + 3'd1 == LAST_BEAT);
                        end
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != RESP_OKAY) begin
                            error_q <= 1'b1;
                        end
                        bready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state     <= RADDR;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat      <= '0;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        if (rd_bad) begin
                            error_q <= 1'b1;
                        end
                        if (beat == LAST_BEAT) begin
                            rready_q <= 1'b0;
                            beat     <= '0;
                            done_q   <= 1'b1;
                            state    <= FIN;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                FIN: begin
                    run_cnt <= run_cnt + 8'd1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
